// File: rtl/mm_mult_seq_128x128.sv
// Sequential 128x128 unsigned multiplier: one 16-bit digit of B per cycle against the
// full A, with digit-shifted partial products accumulated into a 256-bit product.

module mult_partial #(
   parameter int WIDTH_A   = 128,
   parameter int DIGIT_W   = 16,
   parameter int WIDTH_DSP = 26,
   parameter int DSP_NUM   = 5
) (
   input  logic [WIDTH_A-1:0]         a_i,
   input  logic [DIGIT_W-1:0]         d_i,
   output logic [WIDTH_A+DIGIT_W-1:0] p_o
);

   localparam int A_PAD   = DSP_NUM * WIDTH_DSP;
   localparam int SLICE_W = WIDTH_DSP + DIGIT_W;
   localparam int P_W     = WIDTH_A + DIGIT_W;

   logic [A_PAD-1:0]   aPad;
   logic [SLICE_W-1:0] sliceProd [DSP_NUM];
   logic [P_W-1:0]     sum;

   assign aPad = A_PAD'(a_i);

   // Each A slice times the digit maps onto one DSP-sized multiplier.
   always_comb begin
      for (int i = 0; i < DSP_NUM; i++) begin
         sliceProd[i] = SLICE_W'(aPad[i*WIDTH_DSP +: WIDTH_DSP]) * SLICE_W'(d_i);
      end
   end

   // The padded top slice holds only zeros above WIDTH_A, so truncating to P_W is exact.
   always_comb begin
      sum = '0;
      for (int i = 0; i < DSP_NUM; i++) begin
         sum = sum + (P_W'(sliceProd[i]) << (i * WIDTH_DSP));
      end
   end

   assign p_o = sum;

endmodule

module mm_mult_seq_128x128 #(
   parameter int WIDTH_A   = 128,
   parameter int WIDTH_B   = 128,
   parameter int DIGIT_W   = 16,
   parameter int WIDTH_DSP = 26,
   parameter int DSP_NUM   = 5
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH_A-1:0]         a_in,
   input  logic [WIDTH_B-1:0]         b_in,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH_A+WIDTH_B-1:0] p_out,
   output logic                       busy
);

   localparam int NUM_DIG = WIDTH_B / DIGIT_W;
   localparam int CNT_W   = $clog2(NUM_DIG);
   localparam int ACC_W   = WIDTH_A + WIDTH_B;
   localparam int PP_W    = WIDTH_A + DIGIT_W;
   localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NUM_DIG - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [ACC_W-1:0]   acc_q;
   logic [ACC_W-1:0]   acc_d;
   logic [WIDTH_A-1:0] a_q;
   logic [WIDTH_B-1:0] b_q;
   logic               outValid_q;
   logic               busy_q;

   logic [DIGIT_W-1:0] bDigits [NUM_DIG];
   logic [DIGIT_W-1:0] digit;
   logic [PP_W-1:0]    pp;
   logic               accept;

   assign in_ready = (state_q == IDLE) | ((state_q == DONE) & out_ready);
   assign accept   = in_valid & in_ready;

   // Digits are indexed through an array so the select is a plain 8-way mux on cnt.
   always_comb begin
      for (int j = 0; j < NUM_DIG; j++) begin
         bDigits[j] = b_q[j*DIGIT_W +: DIGIT_W];
      end
   end

   assign digit = bDigits[cnt_q];

   mult_partial #(
      .WIDTH_A  (WIDTH_A),
      .DIGIT_W  (DIGIT_W),
      .WIDTH_DSP(WIDTH_DSP),
      .DSP_NUM  (DSP_NUM)
   ) uPartial (
      .a_i(a_q),
      .d_i(digit),
      .p_o(pp)
   );

   always_comb begin
      acc_d = acc_q + (ACC_W'(pp) << (cnt_q * DIGIT_W));
   end

   // A new operand pair may be taken from IDLE or straight out of DONE (back-to-back).
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         acc_q      <= '0;
         a_q        <= '0;
         b_q        <= '0;
         outValid_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  a_q     <= a_in;
                  b_q     <= b_in;
                  cnt_q   <= '0;
                  acc_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end
            end
            RUN: begin
               acc_q <= acc_d;
               if (cnt_q == LAST_DIG) begin
                  cnt_q      <= '0;
                  outValid_q <= 1'b1;
                  state_q    <= DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  outValid_q <= 1'b0;
                  if (accept) begin
                     a_q     <= a_in;
                     b_q     <= b_in;
                     cnt_q   <= '0;
                     acc_q   <= '0;
                     state_q <= RUN;
                  end else begin
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end
               end
            end
            default: begin
               state_q    <= IDLE;
               cnt_q      <= '0;
               outValid_q <= 1'b0;
               busy_q     <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid = outValid_q;
   assign busy      = busy_q;
   assign p_out     = acc_q;

endmodule

// File: tb/tb_mm_mult_seq_128x128.sv
// Directed and randomised checks of mm_mult_seq_128x128 against hand-computed products
// and a 256-bit reference multiply.

module tb_mm_mult_seq_128x128;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] a_in;
   logic [127:0] b_in;
   logic         out_valid;
   logic         out_ready;
   logic [255:0] p_out;
   logic         busy;

   int checks;
   int errors;

   mm_mult_seq_128x128 dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a_in     (a_in),
      .b_in     (b_in),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .p_out    (p_out),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one operand pair and holds it until the edge that accepts it.
   task automatic send(input logic [127:0] a, input logic [127:0] b);
      int guard;
      guard    = 0;
      a_in     = a;
      b_in     = b;
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && guard < 40) begin
         tick();
         guard++;
      end
      if (guard >= 40) begin
         checks++;
         errors++;
         $display("[TB] FAIL send_timeout in_ready=%b required=1", in_ready);
      end
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a_in      = '0;
      b_in      = '0;
      tick();
      tick();
      rst = 1'b0;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_in_ready got=%b exp=1", in_ready);
      end
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_busy got=%b exp=0", busy);
      end
      checks++;
      if (p_out !== 256'h0) begin
         errors++;
         $display("[TB] FAIL reset_p_out got=%h exp=0", p_out);
      end
   endtask

   task automatic test_basic();
      int lat;
      out_ready = 1'b1;
      send(128'h1, 128'h1);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL t1_busy_run got=%b exp=1", busy);
      end
      wait_valid(lat);
      checks++;
      if (lat != 8) begin
         errors++;
         $display("[TB] FAIL t1_latency got=%0d exp=8", lat);
      end
      checks++;
      if (p_out !== 256'h1) begin
         errors++;
         $display("[TB] FAIL t1_product got=%h exp=1", p_out);
      end
      tick();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL t1_idle in_ready=%b out_valid=%b busy=%b exp=1,0,0",
                  in_ready, out_valid, busy);
      end
   endtask

   task automatic test_max_carry();
      int lat;
      logic [255:0] exp;
      exp = {128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 128'h1};
      send({128{1'b1}}, {128{1'b1}});
      wait_valid(lat);
      checks++;
      if (lat != 8) begin
         errors++;
         $display("[TB] FAIL t2_latency got=%0d exp=8", lat);
      end
      checks++;
      if (p_out !== exp) begin
         errors++;
         $display("[TB] FAIL t2_product got=%h exp=%h", p_out, exp);
      end
      tick();
   endtask

   task automatic test_top_digit();
      int lat;
      logic [255:0] exp;
      exp = 256'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_0000_0000_0000_0000_0000_0000_0000;
      send(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 128'h1 << 112);
      a_in = {4{32'hA5A5_5A5A}};
      b_in = {4{32'h1234_5678}};
      wait_valid(lat);
      checks++;
      if (p_out !== exp) begin
         errors++;
         $display("[TB] FAIL t3_product got=%h exp=%h", p_out, exp);
      end
      tick();
   endtask

   task automatic test_stall();
      int lat;
      out_ready = 1'b0;
      send(128'd3, 128'd5);
      wait_valid(lat);
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1;
         a_in     = 128'd99;
         b_in     = 128'd99;
         #1;
         checks++;
         if (out_valid !== 1'b1 || p_out !== 256'd15) begin
            errors++;
            $display("[TB] FAIL t4_hold cyc=%0d out_valid=%b p_out=%h exp=1,f", k, out_valid, p_out);
         end
         checks++;
         if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL t4_in_ready cyc=%0d got=%b exp=0", k, in_ready);
         end
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL t4_release out_valid=%b busy=%b in_ready=%b exp=0,0,1",
                  out_valid, busy, in_ready);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      out_ready = 1'b1;
      send(128'hDEAD_BEEF, 128'h1_0000_0001);
      in_valid = 1'b1;
      a_in     = 128'h1_0000;
      b_in     = 128'hFFFF_FFFF;
      wait_valid(lat);
      checks++;
      if (lat != 8 || p_out !== 256'hDEAD_BEEF_DEAD_BEEF) begin
         errors++;
         $display("[TB] FAIL t5_first lat=%0d p_out=%h exp=8,deadbeefdeadbeef", lat, p_out);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL t5_in_ready_done got=%b exp=1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL t5_no_bubble busy=%b out_valid=%b exp=1,0", busy, out_valid);
      end
      wait_valid(lat);
      checks++;
      if (lat != 8 || p_out !== 256'hFFFF_FFFF_0000) begin
         errors++;
         $display("[TB] FAIL t5_second lat=%0d p_out=%h exp=8,ffffffff0000", lat, p_out);
      end
      tick();
   endtask

   task automatic test_reset_mid_run();
      int lat;
      out_ready = 1'b1;
      send({128{1'b1}}, {128{1'b1}});
      repeat (4) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL t6_abort out_valid=%b busy=%b in_ready=%b exp=0,0,1",
                  out_valid, busy, in_ready);
      end
      send(128'h10, 128'h20);
      wait_valid(lat);
      checks++;
      if (lat != 8 || p_out !== 256'h200) begin
         errors++;
         $display("[TB] FAIL t6_after lat=%0d p_out=%h exp=8,200", lat, p_out);
      end
      tick();
   endtask

   task automatic test_random();
      int lat;
      int stall;
      logic [127:0] a;
      logic [127:0] b;
      logic [255:0] exp;
      for (int n = 0; n < 40; n++) begin
         a = {$urandom(), $urandom(), $urandom(), $urandom()};
         b = {$urandom(), $urandom(), $urandom(), $urandom()};
         if (n % 5 == 0) b[63:32] = '0;
         exp       = 256'(a) * 256'(b);
         out_ready = 1'($urandom_range(0, 1));
         send(a, b);
         a_in = ~a;
         b_in = ~b;
         wait_valid(lat);
         stall     = $urandom_range(0, 3);
         out_ready = 1'b0;
         repeat (stall) tick();
         checks++;
         if (lat != 8 || out_valid !== 1'b1 || p_out !== exp) begin
            errors++;
            $display("[TB] FAIL rand_%0d lat=%0d out_valid=%b p_out=%h exp=%h",
                     n, lat, out_valid, p_out, exp);
         end
         out_ready = 1'b1;
         tick();
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_basic();
      test_max_carry();
      test_top_digit();
      test_stall();
      test_back_to_back();
      test_reset_mid_run();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
